// File: rtl/pass_seq_pkg.sv
// Shared state encoding and pass codes for the training pass sequencer.
package pass_seq_pkg;

  localparam logic [2:0] ST_IDLE      = 3'b000;
  localparam logic [2:0] ST_F0        = 3'b001;
  localparam logic [2:0] ST_F1        = 3'b010;
  localparam logic [2:0] ST_BWD       = 3'b011;
  localparam logic [2:0] ST_EPOCH_END = 3'b100;
  localparam logic [2:0] ST_DONE      = 3'b101;

  typedef enum logic [2:0] {
    StIdle     = ST_IDLE,
    StF0       = ST_F0,
    StF1       = ST_F1,
    StBwd      = ST_BWD,
    StEpochEnd = ST_EPOCH_END,
    StDone     = ST_DONE
  } state_e;

  // Pass codes are one-hot as {b, f1, f0}.
  localparam logic [2:0] PASS_NONE = 3'b000;
  localparam logic [2:0] PASS_F0   = 3'b001;
  localparam logic [2:0] PASS_F1   = 3'b010;
  localparam logic [2:0] PASS_B    = 3'b100;

  function automatic logic [2:0] pass_code(input state_e st);
    logic [2:0] code;
    case (st)
      StF0:    code = PASS_F0;
      StF1:    code = PASS_F1;
      StBwd:   code = PASS_B;
      default: code = PASS_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/layer_counter.sv
// Loadable up/down layer counter with first (zero) and last (MaxVal) flags.
module layer_counter #(
  parameter int unsigned Width  = 2,
  parameter int unsigned MaxVal = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             step_i,
  input  logic             down_i,
  output logic [Width-1:0] count_o,
  output logic             first_o,
  output logic             last_o
);

  localparam logic [Width-1:0] LastVal = Width'(MaxVal);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (step_i) begin
      count_d = down_i ? count_q - 1'b1 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign first_o = (count_q == '0);
  assign last_o  = (count_q == LastVal);

endmodule

// File: rtl/pass_sequencer.sv
// Sequences F0, F1 and backward layer commands per epoch over a valid/ready/done handshake.
// Define PASS_SEQ_BWD_EN to enable the backward pass; otherwise F1 ends each epoch.
module pass_sequencer
  import pass_seq_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned EPOCH_W    = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en_i,
  input  logic                          start_i,
  input  logic                          abort_i,
  input  logic [EPOCH_W-1:0]            num_epochs_i,
  input  logic                          cmd_ready_i,
  input  logic                          step_done_i,
  output logic                          cmd_valid_o,
  output logic [$clog2(NUM_LAYERS)-1:0] layer_o,
  output logic                          f0_pass_o,
  output logic                          f1_pass_o,
  output logic                          b_pass_o,
  output logic [EPOCH_W-1:0]            epoch_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [2:0]                    curr_state_o
);

  localparam int unsigned LW = $clog2(NUM_LAYERS);
  localparam logic [LW-1:0]      LastLayer = LW'(NUM_LAYERS - 1);
  localparam logic [EPOCH_W-1:0] EpochOne  = EPOCH_W'(1);

  state_e             state_q, state_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic               wait_q, wait_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic [EPOCH_W-1:0] target_q, target_d;
  logic [2:0]         pass_q, pass_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic          cnt_load, cnt_step, cnt_down;
  logic [LW-1:0] cnt_load_val, cnt_val;
  logic          cnt_first, cnt_last;
  logic          in_pass, pass_last, step_fire;

  layer_counter #(
    .Width  (LW),
    .MaxVal (NUM_LAYERS - 1)
  ) u_layer_counter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (en_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .step_i     (cnt_step),
    .down_i     (cnt_down),
    .count_o    (cnt_val),
    .first_o    (cnt_first),
    .last_o     (cnt_last)
  );

`ifdef PASS_SEQ_BWD_EN
  assign in_pass = (state_q == StF0) || (state_q == StF1) || (state_q == StBwd);
`else
  assign in_pass = (state_q == StF0) || (state_q == StF1);
`endif
  assign pass_last = (state_q == StBwd) ? cnt_first : cnt_last;
  // Done only counts once the command was accepted on an earlier edge.
  assign step_fire = in_pass && wait_q && step_done_i;

  always_comb begin
    state_d      = state_q;
    cmd_valid_d  = cmd_valid_q;
    wait_d       = wait_q;
    epoch_d      = epoch_q;
    target_d     = target_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_step     = 1'b0;
    cnt_down     = 1'b0;

    if (in_pass) begin
      if (cmd_valid_q && cmd_ready_i) begin
        cmd_valid_d = 1'b0;
        wait_d      = 1'b1;
      end else if (step_fire) begin
        cmd_valid_d = 1'b1;
        wait_d      = 1'b0;
      end
    end

    if (abort_i) begin
      state_d     = StIdle;
      cmd_valid_d = 1'b0;
      wait_d      = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            target_d    = (num_epochs_i == '0) ? EpochOne : num_epochs_i;
            epoch_d     = '0;
            cnt_load    = 1'b1;
            state_d     = StF0;
            cmd_valid_d = 1'b1;
            wait_d      = 1'b0;
          end
        end
        StF0: begin
          if (step_fire) begin
            if (pass_last) begin
              state_d  = StF1;
              cnt_load = 1'b1;
            end else begin
              cnt_step = 1'b1;
            end
          end
        end
        StF1: begin
          if (step_fire) begin
            if (pass_last) begin
`ifdef PASS_SEQ_BWD_EN
              state_d      = StBwd;
              cnt_load     = 1'b1;
              cnt_load_val = LastLayer;
`else
              state_d      = StEpochEnd;
              cmd_valid_d  = 1'b0;
`endif
            end else begin
              cnt_step = 1'b1;
            end
          end
        end
`ifdef PASS_SEQ_BWD_EN
        StBwd: begin
          if (step_fire) begin
            if (pass_last) begin
              state_d     = StEpochEnd;
              cmd_valid_d = 1'b0;
            end else begin
              cnt_step = 1'b1;
              cnt_down = 1'b1;
            end
          end
        end
`endif
        StEpochEnd: begin
          epoch_d = epoch_q + EpochOne;
          if (epoch_d == target_q) begin
            state_d = StDone;
          end else begin
            state_d     = StF0;
            cnt_load    = 1'b1;
            cmd_valid_d = 1'b1;
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d     = StIdle;
          cmd_valid_d = 1'b0;
          wait_d      = 1'b0;
        end
      endcase
    end

`ifdef PASS_SEQ_BWD_EN
    pass_d = pass_code(state_d);
`else
    pass_d = pass_code(state_d) & ~PASS_B;
`endif
    busy_d = (state_d != StIdle) && (state_d != StDone);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= StIdle;
      cmd_valid_q <= 1'b0;
      wait_q      <= 1'b0;
      epoch_q     <= '0;
      target_q    <= '0;
      pass_q      <= PASS_NONE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (en_i) begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      wait_q      <= wait_d;
      epoch_q     <= epoch_d;
      target_q    <= target_d;
      pass_q      <= pass_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cmd_valid_o  = cmd_valid_q;
  assign layer_o      = cnt_val;
  assign f0_pass_o    = pass_q[0];
  assign f1_pass_o    = pass_q[1];
  assign b_pass_o     = pass_q[2];
  assign epoch_o      = epoch_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign curr_state_o = state_q;

endmodule

// File: tb/tb_pass_sequencer.sv
// Scoreboard bench for pass_sequencer: expected commands queued at start, checked on accept.
module tb_pass_sequencer;

  localparam int NL = 4;
`ifdef PASS_SEQ_BWD_EN
  localparam int CPE = 3 * NL;
`else
  localparam int CPE = 2 * NL;
`endif

  typedef struct packed {
    logic [7:0] epoch;
    logic [2:0] pass;
    logic [3:0] layer;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic       en_i = 1'b1;
  logic       start_i = 1'b0;
  logic       abort_i = 1'b0;
  logic [7:0] num_epochs_i = 8'd0;
  logic       cmd_ready_i = 1'b1;
  logic       step_done_i = 1'b1;
  logic       cmd_valid_o;
  logic [1:0] layer_o;
  logic       f0_pass_o, f1_pass_o, b_pass_o;
  logic [7:0] epoch_o;
  logic       busy_o, done_o;
  logic [2:0] curr_state_o;

  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  int   acc_cnt = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  pass_sequencer #(
    .NUM_LAYERS (NL),
    .EPOCH_W    (8)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .num_epochs_i (num_epochs_i),
    .cmd_ready_i  (cmd_ready_i),
    .step_done_i  (step_done_i),
    .cmd_valid_o  (cmd_valid_o),
    .layer_o      (layer_o),
    .f0_pass_o    (f0_pass_o),
    .f1_pass_o    (f1_pass_o),
    .b_pass_o     (b_pass_o),
    .epoch_o      (epoch_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .curr_state_o (curr_state_o)
  );

  // Monitor: inputs change at posedge+1, so the negedge sees what the next edge samples.
  always @(negedge clk) begin
    exp_t got, want;
    if (rst_i && en_i) begin
      if (done_o) done_cnt++;
`ifndef PASS_SEQ_BWD_EN
      if (b_pass_o) begin
        checks++;
        errors++;
        $display("FAIL b_pass_disabled: got 1 expected 0");
      end
`endif
      if (!abort_i && cmd_valid_o && cmd_ready_i) begin
        acc_cnt++;
        checks++;
        got.epoch = epoch_o;
        got.pass  = {b_pass_o, f1_pass_o, f0_pass_o};
        got.layer = 4'(layer_o);
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL cmd_unexpected: got epoch=%0d pass=%b layer=%0d expected none",
                   got.epoch, got.pass, got.layer);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL cmd: got epoch=%0d pass=%b layer=%0d expected epoch=%0d pass=%b layer=%0d",
                     got.epoch, got.pass, got.layer, want.epoch, want.pass, want.layer);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_run(input int n);
    exp_t e;
    for (int ep = 0; ep < n; ep++) begin
      e.epoch = 8'(ep);
      e.pass = 3'b001;
      for (int l = 0; l < NL; l++) begin e.layer = 4'(l); exp_q.push_back(e); end
      e.pass = 3'b010;
      for (int l = 0; l < NL; l++) begin e.layer = 4'(l); exp_q.push_back(e); end
`ifdef PASS_SEQ_BWD_EN
      e.pass = 3'b100;
      for (int l = NL - 1; l >= 0; l--) begin e.layer = 4'(l); exp_q.push_back(e); end
`endif
    end
  endtask

  task automatic start_run(input int n_in);
    num_epochs_i = 8'(n_in);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_cmd(input logic [2:0] pass, input int layer, input int epoch,
                          output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (cmd_valid_o && {b_pass_o, f1_pass_o, f0_pass_o} == pass &&
          32'(layer_o) == layer && 32'(epoch_o) == epoch) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic finish_run(input string name, input int n_eff, input int d0, input int a0);
    bit ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (done_cnt > d0) begin ok = 1'b1; break; end
    end
    chk({name, "_done_seen"}, 32'(ok), 1);
    repeat (3) tick();
    chk({name, "_epoch"}, 32'(epoch_o), 32'(n_eff));
    chk({name, "_done_pulses"}, 32'(done_cnt - d0), 1);
    chk({name, "_cmds"}, 32'(acc_cnt - a0), 32'(n_eff * CPE));
    chk({name, "_queue_left"}, 32'(exp_q.size()), 0);
    chk({name, "_idle"}, 32'({busy_o, curr_state_o}), 0);
  endtask

  task automatic full_run(input string name, input int n_in, input int n_eff);
    int d0 = done_cnt;
    int a0 = acc_cnt;
    push_run(n_eff);
    start_run(n_in);
    finish_run(name, n_eff, d0, a0);
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_valid"}, 32'(cmd_valid_o), 0);
    chk({name, "_layer"}, 32'(layer_o), 0);
    chk({name, "_flags"}, 32'({b_pass_o, f1_pass_o, f0_pass_o}), 0);
    chk({name, "_epoch"}, 32'(epoch_o), 0);
    chk({name, "_busy_done"}, 32'({busy_o, done_o}), 0);
    chk({name, "_state"}, 32'(curr_state_o), 0);
  endtask

  logic [2:0] late_pass;
  bit ok;
  int d0, a0;

  initial begin
`ifdef PASS_SEQ_BWD_EN
    late_pass = 3'b100;
`else
    late_pass = 3'b010;
`endif
    repeat (2) tick();
    chk_reset_vals("reset");
    rst_i = 1'b1;
    tick();

    full_run("basic1", 1, 1);
    full_run("zero_epochs", 0, 1);
    full_run("three_epochs", 3, 3);

    // Ready stall with step_done held high: nothing may move.
    d0 = done_cnt;
    a0 = acc_cnt;
    cmd_ready_i = 1'b0;
    push_run(1);
    start_run(1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(cmd_valid_o), 1);
      chk("stall_layer_pass", 32'({layer_o, b_pass_o, f1_pass_o, f0_pass_o}), 32'(5'b00001));
      chk("stall_state", 32'(curr_state_o), 1);
      tick();
    end
    cmd_ready_i = 1'b1;
    finish_run("stall", 1, d0, a0);

    // Abort in the last pass, layer 2, second epoch.
    d0 = done_cnt;
    push_run(2);
    start_run(2);
    wait_cmd(late_pass, 2, 1, ok);
    chk("abort_reach", 32'(ok), 1);
    tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_state", 32'(curr_state_o), 0);
    chk("abort_valid_busy", 32'({cmd_valid_o, busy_o}), 0);
    chk("abort_flags", 32'({b_pass_o, f1_pass_o, f0_pass_o}), 0);
    exp_q.delete();
    repeat (4) tick();
    chk("abort_no_done", 32'(done_cnt - d0), 0);
    d0 = done_cnt;
    a0 = acc_cnt;
    push_run(1);
    start_run(1);
    chk("restart_first", 32'({cmd_valid_o, layer_o, b_pass_o, f1_pass_o, f0_pass_o}),
        32'(6'b100001));
    chk("restart_epoch", 32'(epoch_o), 0);
    finish_run("restart", 1, d0, a0);

    // Freeze mid-F1 (after accepting layer 1), then reset mid-run with en_i low.
    push_run(1);
    start_run(1);
    wait_cmd(3'b010, 1, 0, ok);
    chk("freeze_reach", 32'(ok), 1);
    tick();
    en_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("freeze_state", 32'(curr_state_o), 2);
      chk("freeze_outs", 32'({cmd_valid_o, layer_o, b_pass_o, f1_pass_o, f0_pass_o, busy_o}),
          32'(7'b0010101));
      chk("freeze_epoch", 32'(epoch_o), 0);
    end
    en_i = 1'b1;
    wait_cmd(3'b010, 3, 0, ok);
    chk("reset_reach", 32'(ok), 1);
    tick();
    rst_i = 1'b0;
    en_i = 1'b0;
    tick();
    chk_reset_vals("midrun_reset");
    rst_i = 1'b1;
    en_i = 1'b1;
    exp_q.delete();
    tick();

    full_run("post_reset", 1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
